// File: rtl/alu_frame_pkg.sv
// Shared definitions for the framed ALU command sequencer.
// ALU_FRAME_CHECKSUM_EN selects 5-byte requests / 4-byte responses with a trailing XOR checksum.
package alu_frame_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE      = 4'd0;
    localparam state_t ST_GET_OP    = 4'd1;
    localparam state_t ST_GET_A     = 4'd2;
    localparam state_t ST_GET_B     = 4'd3;
    localparam state_t ST_GET_CHK   = 4'd4;
    localparam state_t ST_EXEC      = 4'd5;
    localparam state_t ST_LOAD      = 4'd6;
    localparam state_t ST_SEND      = 4'd7;
    localparam state_t ST_WAIT_DONE = 4'd8;

    localparam logic [7:0] ERR_CHK = 8'h01;
    localparam logic [7:0] ERR_OP  = 8'h02;

`ifdef ALU_FRAME_CHECKSUM_EN
    localparam int RESP_LEN = 4;
`else
    localparam int RESP_LEN = 3;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/rx_gap_timer.sv
// Inter-byte gap counter: counts while enabled, holds at TIMEOUT_CYC-1 and flags expire there.
module rx_gap_timer #(
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_frame_ctrl.sv
// Framed-command sequencer between RX FIFO, ALU and uart_tx.
// Define ALU_FRAME_CHECKSUM_EN to require/emit the trailing XOR checksum byte.
module alu_frame_ctrl
    import alu_frame_pkg::*;
#(
    parameter int                  NB_DATA     = 8,
    parameter int                  NB_OP       = NB_DATA - 2,
    parameter logic [NB_DATA-1:0]  SOF         = 8'hA5,
    parameter logic [NB_DATA-1:0]  ACK         = 8'h5A,
    parameter logic [NB_DATA-1:0]  NAK         = 8'hEE,
    parameter int                  TIMEOUT_CYC = 1_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_empty,
    input  logic [NB_DATA-1:0] rx_data,
    output logic               rx_rd,
    input  logic               tx_done_tick,
    output logic               tx_start,
    output logic [NB_DATA-1:0] tx_data,
    output logic [NB_OP-1:0]   alu_op,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    input  logic [NB_DATA-1:0] alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               busy,
    output logic [7:0]         err_cnt
);

    localparam int IDX_W = $clog2(RESP_LEN);

    state_t             state;
    logic [NB_DATA-1:0] op_q, a_q, b_q;
    logic [NB_DATA-1:0] result_q, flags_q, code_q;
    logic               nak_q;
    logic [IDX_W-1:0]   idx;
    logic [NB_DATA-1:0] resp_q    [RESP_LEN];
    logic [NB_DATA-1:0] resp_next [RESP_LEN];
    logic               in_get, op_bad, chk_bad, timeout_hit, gap_expire;
`ifdef ALU_FRAME_CHECKSUM_EN
    logic [NB_DATA-1:0] chk_q;
`endif

    assign in_get   = (state == ST_GET_OP) || (state == ST_GET_A) ||
                      (state == ST_GET_B)  || (state == ST_GET_CHK);
    // Popping is suppressed during reset so the FIFO is never drained by a held reset
    assign rx_rd    = !reset && ((state == ST_IDLE) || in_get) && !rx_empty;
    assign tx_start = (state == ST_SEND);
    assign busy     = (state != ST_IDLE);
    assign alu_op   = op_q[NB_OP-1:0];
    assign alu_a    = a_q;
    assign alu_b    = b_q;

    assign timeout_hit = in_get && rx_empty && gap_expire;
    assign op_bad      = (op_q[NB_DATA-1:NB_OP] != '0);
`ifdef ALU_FRAME_CHECKSUM_EN
    assign chk_bad     = (chk_q != (op_q ^ a_q ^ b_q));
`else
    assign chk_bad     = 1'b0;
`endif

    rx_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (!in_get || rx_rd),
        .enable (in_get && rx_empty),
        .expire (gap_expire)
    );

    always_comb begin
        resp_next[0] = nak_q ? NAK : ACK;
        resp_next[1] = nak_q ? code_q : result_q;
        resp_next[2] = nak_q ? '0 : flags_q;
`ifdef ALU_FRAME_CHECKSUM_EN
        resp_next[3] = resp_next[0] ^ resp_next[1] ^ resp_next[2];
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            code_q   <= '0;
            nak_q    <= 1'b0;
            idx      <= '0;
            tx_data  <= '0;
            err_cnt  <= '0;
`ifdef ALU_FRAME_CHECKSUM_EN
            chk_q    <= '0;
`endif
            for (int i = 0; i < RESP_LEN; i++) resp_q[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_empty && rx_data == SOF) state <= ST_GET_OP;
                end
                ST_GET_OP: begin
                    if (!rx_empty) begin
                        op_q  <= rx_data;
                        state <= ST_GET_A;
                    end
                end
                ST_GET_A: begin
                    if (!rx_empty) begin
                        a_q   <= rx_data;
                        state <= ST_GET_B;
                    end
                end
                ST_GET_B: begin
                    if (!rx_empty) begin
                        b_q   <= rx_data;
`ifdef ALU_FRAME_CHECKSUM_EN
                        state <= ST_GET_CHK;
`else
                        state <= ST_EXEC;
`endif
                    end
                end
`ifdef ALU_FRAME_CHECKSUM_EN
                ST_GET_CHK: begin
                    if (!rx_empty) begin
                        chk_q <= rx_data;
                        state <= ST_EXEC;
                    end
                end
`endif
                // Opcode errors take priority over checksum errors
                ST_EXEC: begin
                    result_q <= alu_result;
                    flags_q  <= {{(NB_DATA-2){1'b0}}, alu_carry, alu_zero};
                    nak_q    <= op_bad || chk_bad;
                    code_q   <= op_bad ? NB_DATA'(ERR_OP) : NB_DATA'(ERR_CHK);
                    if (op_bad || chk_bad) err_cnt <= sat_inc(err_cnt);
                    state    <= ST_LOAD;
                end
                ST_LOAD: begin
                    for (int i = 0; i < RESP_LEN; i++) resp_q[i] <= resp_next[i];
                    tx_data <= resp_next[0];
                    idx     <= '0;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (tx_done_tick) begin
                        if (idx == IDX_W'(RESP_LEN - 1)) begin
                            state <= ST_IDLE;
                        end else begin
                            idx     <= idx + 1'b1;
                            tx_data <= resp_q[idx + 1'b1];
                            state   <= ST_SEND;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A stalled frame is dropped silently; only the error counter records it
            if (timeout_hit) begin
                state   <= ST_IDLE;
                err_cnt <= sat_inc(err_cnt);
            end
        end
    end

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Scoreboard bench for alu_frame_ctrl with a FIFO, combinational ALU and uart_tx model.
// Works with or without ALU_FRAME_CHECKSUM_EN defined.
module tb_alu_frame_ctrl;
    import alu_frame_pkg::*;

    localparam int T_CYC = 50;
`ifdef ALU_FRAME_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_empty, rx_rd, tx_done_tick, tx_start, busy;
    logic [7:0] rx_data, tx_data, alu_a, alu_b, alu_result, err_cnt;
    logic [5:0] alu_op;
    logic       alu_carry, alu_zero;

    alu_frame_ctrl #(.TIMEOUT_CYC(T_CYC)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_empty     (rx_empty),
        .rx_data      (rx_data),
        .rx_rd        (rx_rd),
        .tx_done_tick (tx_done_tick),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_zero     (alu_zero),
        .busy         (busy),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // FIFO model: stimulus owns wr_ptr/mem, the pop process owns rd_ptr
    logic [7:0] fifo_mem [256];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int cyc = 0;
    int last_pop_cyc = 0;

    assign rx_empty = (wr_ptr == rd_ptr);
    assign rx_data  = fifo_mem[rd_ptr[7:0]];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_rd) begin
            rd_ptr       <= rd_ptr + 1;
            last_pop_cyc <= cyc;
        end
    end

    // ALU model: ADD 20, SUB 22 (carry = borrow), AND 24
    logic [8:0] alu_full;
    always_comb begin
        alu_full = '0;
        case (alu_op)
            6'h20:   alu_full = {1'b0, alu_a} + {1'b0, alu_b};
            6'h22:   alu_full = {1'b0, alu_a} - {1'b0, alu_b};
            6'h24:   alu_full = {1'b0, alu_a & alu_b};
            default: alu_full = '0;
        endcase
    end
    assign alu_result = alu_full[7:0];
    assign alu_carry  = alu_full[8];
    assign alu_zero   = (alu_full[7:0] == 8'h00);

    // uart_tx model: done tick five cycles after each start pulse
    logic [2:0] u_cnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            u_cnt        <= '0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            if (tx_start) begin
                u_cnt <= 3'd4;
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1'b1;
                if (u_cnt == 3'd1) tx_done_tick <= 1'b1;
            end
        end
    end

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] exp;
    } stat_t;

    logic [7:0] exp_q [$];
    stat_t      stat_q [$];
    int         checks = 0;
    int         errors = 0;
    int         sent_cnt = 0;
    int         sent_base = 0;
    int         byte_idx = 0;
    int         exp_err = 0;
    logic [7:0] last_exp = '0;
    logic [7:0] exp_byte, act;
    stat_t      st;

    function automatic logic [7:0] probe(input int sel);
        case (sel)
            0:       return {7'b0, busy};
            1:       return {7'b0, tx_start};
            2:       return {7'b0, rx_rd};
            3:       return tx_data;
            4:       return {2'b0, alu_op};
            5:       return alu_a;
            6:       return alu_b;
            7:       return err_cnt;
            8:       return {7'b0, (!busy && exp_q.size() == 0)};
            9:       return 8'(wr_ptr - rd_ptr);
            10:      return 8'(sent_cnt - sent_base);
            default: return 8'hXX;
        endcase
    endfunction

    // Monitor: pops expected response bytes on tx_start and evaluates queued status checks
    always @(negedge clk) begin
        if (reset) begin
            byte_idx = 0;
        end else begin
            if (tx_start) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected_tx_start got %02h required none", tx_data);
                end else begin
                    exp_byte = exp_q.pop_front();
                    last_exp = exp_byte;
                    if (tx_data !== exp_byte) begin
                        errors++;
                        $display("[TB] FAIL resp_byte%0d got %02h required %02h", byte_idx, tx_data, exp_byte);
                    end
                    if (byte_idx == 0) begin
                        checks++;
                        if (cyc - last_pop_cyc != 3) begin
                            errors++;
                            $display("[TB] FAIL latency got %0d required 3", cyc - last_pop_cyc);
                        end
                    end
                    byte_idx = (byte_idx == RESP_LEN - 1) ? 0 : byte_idx + 1;
                    sent_cnt++;
                end
            end
            if (tx_done_tick) begin
                checks++;
                if (tx_data !== last_exp) begin
                    errors++;
                    $display("[TB] FAIL tx_hold got %02h required %02h", tx_data, last_exp);
                end
            end
        end
        while (stat_q.size() > 0) begin
            st  = stat_q.pop_front();
            act = probe(st.sel);
            checks++;
            if (act !== st.exp) begin
                errors++;
                $display("[TB] FAIL %s got %02h required %02h", st.name, act, st.exp);
            end
        end
    end

    task automatic check_output(input string name, input int sel, input logic [7:0] exp);
        stat_q.push_back('{name, sel, exp});
        @(negedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] v);
        fifo_mem[wr_ptr[7:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic apply_stimulus(input logic [7:0] op, input logic [7:0] a,
                                  input logic [7:0] b, input logic [7:0] chk);
        push_byte(8'hA5);
        push_byte(op);
        push_byte(a);
        push_byte(b);
        if (CHK_EN) push_byte(chk);
    endtask

    task automatic expect_resp(input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back(b0);
        exp_q.push_back(b1);
        exp_q.push_back(b2);
        if (CHK_EN) exp_q.push_back(b3);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            if (!busy && exp_q.size() == 0 && rx_empty) break;
        end
        check_output(name, 8, 8'h01);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Garbage bytes sit in the FIFO during reset and must not be popped
        push_byte(8'h11);
        push_byte(8'h22);
        @(negedge clk);
        #1;
        check_output("rst_busy",     0, 8'h00);
        check_output("rst_tx_start", 1, 8'h00);
        check_output("rst_rx_rd",    2, 8'h00);
        check_output("rst_tx_data",  3, 8'h00);
        check_output("rst_alu_op",   4, 8'h00);
        check_output("rst_alu_a",    5, 8'h00);
        check_output("rst_alu_b",    6, 8'h00);
        check_output("rst_err_cnt",  7, 8'h00);
        check_output("rst_fifo_kept", 9, 8'h02);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Garbage is discarded, then ADD 05+03
        expect_resp(8'h5A, 8'h08, 8'h00, 8'h52);
        apply_stimulus(8'h20, 8'h05, 8'h03, 8'h26);
        wait_idle("add_idle");
        check_output("add_err_cnt", 7, 8'h00);
        check_output("add_alu_op",  4, 8'h20);
        check_output("add_alu_a",   5, 8'h05);
        check_output("add_alu_b",   6, 8'h03);
        check_output("add_fifo_drained", 9, 8'h00);

        // ADD FF+01: carry and zero both set
        expect_resp(8'h5A, 8'h00, 8'h03, 8'h59);
        apply_stimulus(8'h20, 8'hFF, 8'h01, 8'hDE);
        wait_idle("carry_idle");

        // Opcode with nonzero upper bits
        expect_resp(8'hEE, 8'h02, 8'h00, 8'hEC);
        apply_stimulus(8'h60, 8'h05, 8'h03, 8'h66);
        wait_idle("badop_idle");
        exp_err = 1;
        check_output("badop_err_cnt", 7, 8'(exp_err));

        if (CHK_EN) begin
            expect_resp(8'hEE, 8'h01, 8'h00, 8'hEF);
            apply_stimulus(8'h20, 8'h05, 8'h03, 8'h00);
            wait_idle("badchk_idle");
            exp_err = exp_err + 1;
            check_output("badchk_err_cnt", 7, 8'(exp_err));
        end

        // Garbage ahead of a SUB frame
        push_byte(8'h11);
        push_byte(8'h22);
        expect_resp(8'h5A, 8'h05, 8'h00, 8'h5F);
        apply_stimulus(8'h22, 8'h09, 8'h04, 8'h2F);
        wait_idle("sub_idle");
        check_output("sub_fifo_drained", 9, 8'h00);

        // Truncated frame: still waiting mid-gap, then dropped
        push_byte(8'hA5);
        push_byte(8'h20);
        repeat (40) @(posedge clk);
        #1;
        check_output("gap_still_busy", 0, 8'h01);
        repeat (20) @(posedge clk);
        #1;
        check_output("timeout_idle", 0, 8'h00);
        exp_err = exp_err + 1;
        check_output("timeout_err_cnt", 7, 8'(exp_err));

        expect_resp(8'h5A, 8'h30, 8'h00, 8'h6A);
        apply_stimulus(8'h24, 8'hF0, 8'h3C, 8'hE8);
        wait_idle("and_idle");
        check_output("and_err_cnt", 7, 8'(exp_err));

        // Reset while waiting for byte 2 to finish transmitting
        sent_base = sent_cnt;
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h08);
        apply_stimulus(8'h20, 8'h05, 8'h03, 8'h26);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (sent_cnt - sent_base >= 2) break;
        end
        check_output("midresp_progress", 10, 8'h02);
        check_output("midresp_busy", 0, 8'h01);
        @(posedge clk);
        #1;
        reset = 1'b1;
        check_output("mrst_busy",     0, 8'h00);
        check_output("mrst_tx_start", 1, 8'h00);
        check_output("mrst_tx_data",  3, 8'h00);
        check_output("mrst_alu_op",   4, 8'h00);
        check_output("mrst_alu_a",    5, 8'h00);
        check_output("mrst_err_cnt",  7, 8'h00);
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err = 0;

        expect_resp(8'h5A, 8'h10, 8'h00, 8'h4A);
        apply_stimulus(8'h20, 8'h07, 8'h09, 8'h2E);
        wait_idle("post_reset_idle");
        check_output("post_reset_err_cnt", 7, 8'(exp_err));

        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
